// File: rtl/pc_seq_unit.sv
// -----------------------------------------------------------------------------
// pc_seq_unit
//
// Program-counter sequencer for the single-cycle core. Holds the PC register
// and selects the next fetch address every cycle from four sources:
// register jump (jr), pseudo-direct jump (jmp), relative branch (br_take) and
// the sequential pc+STEP increment. A small control FSM (BOOT/RUN/HALT) adds
// the reset vector, stall, halt/resume and a fetch-valid flag.
//
// Parameters
//   N          PC / operand width (>= 8)
//   STEP       sequential increment in bytes (power of two, >= 1)
//   RESET_VEC  PC value loaded on reset
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset, overrides everything
//   stall     in   hold PC this cycle (RUN only); redirects are discarded
//   halt      in   enter HALT (RUN only); beats stall and redirects
//   resume    in   leave HALT; wins over a simultaneous halt
//   br_take   in   take relative branch
//   br_off    in   N-bit sign-extended word offset for the branch
//   jmp       in   take pseudo-direct jump
//   jmp_idx   in   N-6 bit jump word index
//   jr        in   take register jump
//   jr_tgt    in   N-bit absolute jump target
//   pc        out  current PC (registered)
//   pc_plus   out  pc+STEP mod 2^N (combinational)
//   cout      out  carry out of pc+STEP (combinational)
//   pc_valid  out  pc is a live fetch address (registered)
//   align_err out  only with PC_ALIGN_CHK_EN: sticky misaligned-redirect flag
//
// Build option
//   PC_ALIGN_CHK_EN  when defined, a selected jr or branch target with
//                    target[1:0] != 0 is not loaded: the PC holds, align_err
//                    is set (sticky until rst) and the sequencer enters HALT.
//                    When undefined there is no align_err port and misaligned
//                    targets load unchanged.
// -----------------------------------------------------------------------------
module pc_seq_unit #(
   parameter int unsigned  N         = 32,
   parameter int unsigned  STEP      = 4,
   parameter logic [N-1:0] RESET_VEC = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                halt,
   input  logic                resume,
   input  logic                br_take,
   input  logic signed [N-1:0] br_off,
   input  logic                jmp,
   input  logic [N-7:0]        jmp_idx,
   input  logic                jr,
   input  logic [N-1:0]        jr_tgt,
   output logic [N-1:0]        pc,
   output logic [N-1:0]        pc_plus,
   output logic                cout,
   output logic                pc_valid
`ifdef PC_ALIGN_CHK_EN
   ,
   output logic                align_err
`endif
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   // Relative branch: word offset scaled to bytes, added to the sequential
   // address. Wraps modulo 2^N; no overflow is reported.
   function automatic logic [N-1:0] branch_target(
      input logic [N-1:0]        base,
      input logic signed [N-1:0] off
   );
      logic [N-1:0] disp;
      disp = off <<< 2;
      return base + disp;
   endfunction

   // Pseudo-direct jump: keeps the top nibble of the sequential address and
   // replaces the rest with the word index; always word aligned.
   function automatic logic [N-1:0] jump_target(
      input logic [N-1:0] base,
      input logic [N-7:0] idx
   );
      return {base[N-1:N-4], idx, 2'b00};
   endfunction

   state_t       state;
   logic [N-1:0] pc_p0;
   logic         vld_p0;
   logic [N-1:0] nxt_pc;

   // ---- stage p0: combinational next-PC selection from the registered PC ----
   assign {cout, pc_plus} = {1'b0, pc_p0} + (N+1)'(STEP);

   // Priority jr > jmp > br_take > sequential.
   always_comb begin
      nxt_pc = pc_plus;
      if (jr)
         nxt_pc = jr_tgt;
      else if (jmp)
         nxt_pc = jump_target(pc_plus, jmp_idx);
      else if (br_take)
         nxt_pc = branch_target(pc_plus, br_off);
   end

`ifdef PC_ALIGN_CHK_EN
   logic chk_sel;
   logic misaligned;

   // Only jr and branch targets can be misaligned; the jump target is
   // aligned by construction so a jmp (which outranks a branch) is exempt.
   assign chk_sel    = jr | (~jmp & br_take);
   assign misaligned = chk_sel & (nxt_pc[1:0] != 2'b00);
`endif

   // ---- stage p0 -> register: PC, valid flag and control state ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= BOOT;
         pc_p0  <= RESET_VEC;
         vld_p0 <= 1'b0;
`ifdef PC_ALIGN_CHK_EN
         align_err <= 1'b0;
`endif
      end else begin
         case (state)
            // First edge after reset only raises valid: RESET_VEC is the
            // first address fetched. stall/halt/redirects are ignored here.
            BOOT: begin
               state  <= RUN;
               vld_p0 <= 1'b1;
            end

            RUN: begin
               if (halt) begin
                  state  <= HALT;
                  vld_p0 <= 1'b0;
               end else if (!stall) begin
`ifdef PC_ALIGN_CHK_EN
                  if (misaligned) begin
                     state     <= HALT;
                     vld_p0    <= 1'b0;
                     align_err <= 1'b1;
                  end else begin
                     pc_p0 <= nxt_pc;
                  end
`else
                  pc_p0 <= nxt_pc;
`endif
               end
            end

            // PC holds; resume wins over a simultaneous halt.
            HALT: begin
               if (resume) begin
                  state  <= RUN;
                  vld_p0 <= 1'b1;
               end
            end

            default: begin
               state  <= BOOT;
               vld_p0 <= 1'b0;
            end
         endcase
      end
   end

   assign pc       = pc_p0;
   assign pc_valid = vld_p0;

endmodule

// File: tb/tb_pc_seq_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_seq_unit
//
// Scoreboard bench for pc_seq_unit (N=32, STEP=4, RESET_VEC=0x0040_0000).
// The driver applies inputs on the falling edge, asks a behavioural model what
// the DUT outputs must be during that cycle, queues that expectation and then
// advances the model across the next rising edge. A separate monitor pops one
// expectation per cycle and compares pc, pc_plus, cout, pc_valid (and
// align_err when PC_ALIGN_CHK_EN is defined).
// -----------------------------------------------------------------------------
module tb_pc_seq_unit;

   localparam int unsigned  N    = 32;
   localparam int unsigned  STEP = 4;
   localparam logic [31:0]  RV   = 32'h0040_0000;
   localparam longint       MODV = 64'h1_0000_0000;

   logic        clk = 1'b0;
   logic        rst, stall, halt, resume, br_take, jmp, jr;
   logic [31:0] br_off, jr_tgt;
   logic [25:0] jmp_idx;
   logic [31:0] pc, pc_plus;
   logic        cout, pc_valid;
`ifdef PC_ALIGN_CHK_EN
   logic        align_err;
   localparam bit ALIGN_CHK = 1'b1;
`else
   localparam bit ALIGN_CHK = 1'b0;
`endif

   pc_seq_unit #(.N(N), .STEP(STEP), .RESET_VEC(RV)) dut (
      .clk      (clk),
      .rst      (rst),
      .stall    (stall),
      .halt     (halt),
      .resume   (resume),
      .br_take  (br_take),
      .br_off   (br_off),
      .jmp      (jmp),
      .jmp_idx  (jmp_idx),
      .jr       (jr),
      .jr_tgt   (jr_tgt),
      .pc       (pc),
      .pc_plus  (pc_plus),
      .cout     (cout),
      .pc_valid (pc_valid)
`ifdef PC_ALIGN_CHK_EN
      ,
      .align_err(align_err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pp;
      logic        co;
      logic        vld;
      logic        ae;
      int          id;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc_id = 0;

   // Behavioural model: plain integer PC plus three facts about the machine.
   bit     m_known  = 0;  // a reset has been seen
   bit     m_boot   = 0;  // first cycle after reset, not yet fetching
   bit     m_halted = 0;
   bit     m_aerr   = 0;
   longint m_pc     = 0;

   function automatic longint seq_of(longint p);
      return (p + STEP) % MODV;
   endfunction

   // Expected outputs during the current cycle.
   task automatic push_expect();
      exp_t e;
      if (!m_known) return;
      e.pc  = 32'(m_pc);
      e.pp  = 32'(seq_of(m_pc));
      e.co  = ((m_pc + STEP) >= MODV);
      e.vld = !m_boot && !m_halted;
      e.ae  = m_aerr;
      e.id  = cyc_id;
      q.push_back(e);
   endtask

   // What the rising edge does to the model given the driven inputs.
   task automatic model_edge();
      longint tgt;
      longint off;
      bit     checked;
      if (rst) begin
         m_known = 1; m_pc = longint'(RV); m_boot = 1; m_halted = 0; m_aerr = 0;
         return;
      end
      if (!m_known) return;
      if (m_boot) begin m_boot = 0; return; end
      if (m_halted) begin
         if (resume) m_halted = 0;
         return;
      end
      if (halt) begin m_halted = 1; return; end
      if (stall) return;
      checked = 0;
      if (jr) begin
         tgt = longint'(jr_tgt); checked = 1;
      end else if (jmp) begin
         tgt = (seq_of(m_pc) / 64'h1000_0000) * 64'h1000_0000 + longint'(jmp_idx) * 4;
      end else if (br_take) begin
         off = longint'($signed(br_off));
         tgt = (seq_of(m_pc) + off * 4) & 64'hFFFF_FFFF;
         checked = 1;
      end else begin
         tgt = seq_of(m_pc);
      end
      if (ALIGN_CHK && checked && (tgt % 4 != 0)) begin
         m_halted = 1; m_aerr = 1;
         return;
      end
      m_pc = tgt;
   endtask

   // One cycle: inputs are already driven (at a falling edge).
   task automatic step();
      push_expect();
      @(posedge clk);
      model_edge();
      cyc_id++;
      @(negedge clk);
   endtask

   task automatic clear();
      rst = 0; stall = 0; halt = 0; resume = 0; br_take = 0; jmp = 0; jr = 0;
      br_off = '0; jr_tgt = '0; jmp_idx = '0;
   endtask

   task automatic jr_to(input logic [31:0] t);
      clear(); jr = 1; jr_tgt = t; step(); clear();
   endtask

   // Monitor: one comparison set per cycle, well away from the rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (pc !== e.pc) begin
               bad++; $display("FAIL pc cyc=%0d got=%h want=%h", e.id, pc, e.pc);
            end
            total++;
            if (pc_plus !== e.pp) begin
               bad++; $display("FAIL pc_plus cyc=%0d got=%h want=%h", e.id, pc_plus, e.pp);
            end
            total++;
            if (cout !== e.co) begin
               bad++; $display("FAIL cout cyc=%0d got=%b want=%b", e.id, cout, e.co);
            end
            total++;
            if (pc_valid !== e.vld) begin
               bad++; $display("FAIL pc_valid cyc=%0d got=%b want=%b", e.id, pc_valid, e.vld);
            end
`ifdef PC_ALIGN_CHK_EN
            total++;
            if (align_err !== e.ae) begin
               bad++; $display("FAIL align_err cyc=%0d got=%b want=%b", e.id, align_err, e.ae);
            end
`endif
         end
      end
   end

   initial begin
      int r;
      int w;
      clear();
      rst = 1;
      @(negedge clk);
      // Reset two cycles, then boot and sequential fetches.
      step(); step();
      rst = 0;
      step();            // BOOT: pc=RESET_VEC, not valid
      step(); step(); step();

      // Branch back by two words, then jr outranking a branch.
      jr_to(32'h0000_0100);
      br_take = 1; br_off = 32'hFFFF_FFFE; step(); clear();
      step();
      br_take = 1; br_off = 32'hFFFF_FFFE; jr = 1; jr_tgt = 32'h0000_2000; step(); clear();
      step();

      // Pseudo-direct jump; jmp outranks a branch.
      jr_to(32'hA000_0010);
      jmp = 1; jmp_idx = 26'h000_0123; br_take = 1; br_off = 32'h10; step(); clear();
      step();

      // Wrap-around at the top of the address space.
      jr_to(32'hFFFF_FFFC);
      step(); step();

      // Halt, halt+resume together, resume sequence.
      jr_to(32'h0000_0040);
      halt = 1; step(); clear();
      step(); step();
      halt = 1; resume = 1; br_take = 1; br_off = 32'h4; step(); clear();
      step(); step();

      // Stall three cycles with a pending branch: branch is discarded.
      stall = 1; br_take = 1; br_off = 32'h20;
      step(); step(); step();
      clear(); step();

      // halt beats stall and jr; reset mid-halt; halt/stall ignored in BOOT.
      halt = 1; stall = 1; jr = 1; jr_tgt = 32'h0000_0800; step(); clear();
      step();
      rst = 1; halt = 1; step();
      rst = 0; halt = 1; stall = 1; step(); clear();
      step(); step();

`ifdef PC_ALIGN_CHK_EN
      // Misaligned jr target: pc holds, align_err sticky, HALT.
      jr_to(32'h0000_1002);
      step();
      resume = 1; step(); clear();
      step(); step();
      rst = 1; step(); rst = 0;
      step(); step();
`endif

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         clear();
         r = int'($urandom_range(0, 99));
         rst     = (r < 2);
         halt    = ($urandom_range(0, 99) < 6);
         resume  = ($urandom_range(0, 99) < 40);
         stall   = ($urandom_range(0, 99) < 15);
         jr      = ($urandom_range(0, 99) < 12);
         jmp     = ($urandom_range(0, 99) < 12);
         br_take = ($urandom_range(0, 99) < 25);
         w       = int'($urandom_range(0, 128)) - 64;
         br_off  = w;
         jmp_idx = 26'($urandom);
         jr_tgt  = $urandom;
         if ($urandom_range(0, 99) < 80) jr_tgt[1:0] = 2'b00;
         if ($urandom_range(0, 99) < 5)  jr_tgt = 32'hFFFF_FFF8;
         step();
      end
      clear();
      step(); step();

      // Let the monitor drain the queue, bounded.
      for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain left=%0d want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
